// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC register, 2-entry {pc, inst} buffer, push counter.
// Optional IF_ALIGN_CHECK_EN halts fetching after a misaligned redirect.
module inst_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               PC_STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc,
  input  logic             out_ready,
  output logic [15:0]      fetch_cnt,
  output logic             misalign
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] buf_pc   [2];
  logic [WIDTH-1:0] buf_inst [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             pop;
  logic             push;
  logic             halted;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_inst  = buf_inst[rd_ptr];
  assign out_pc    = buf_pc[rd_ptr];

  assign pop  = out_valid && out_ready;
  // A full buffer still accepts a push when its head leaves on the same edge.
  assign push = !stall && !redirect && ((count < 2'd2) || pop) && !halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
      end
    end else if (redirect) begin
      pc     <= redirect_pc;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push) begin
        buf_pc[wr_ptr]   <= pc;
        buf_inst[wr_ptr] <= imem_rdata;
        wr_ptr           <= ~wr_ptr;
        pc               <= pc + WIDTH'(PC_STEP);
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 16'd0;
    end else if (push && (fetch_cnt != 16'hFFFF)) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // Sticky until reset: a bad target stops all further fetching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
      halted   <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign <= 1'b1;
      halted   <= 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model with a per-cycle compare process,
// directed literal checks for the key scenarios, then randomized stall/redirect/ready traffic.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b1;
  logic [15:0] fetch_cnt;
  logic        misalign;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  inst_fetch #(.WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .fetch_cnt(fetch_cnt), .misalign(misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_AA03;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: fetch buffer as a queue, advanced once per rising edge.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    bit m_pop, m_push;
    if (!rst_n) begin
      mq.delete();
      m_pc  = 32'h0;
      m_cnt = 0;
    end else begin
      m_pop = (mq.size() > 0) && out_ready;
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc;
      end else begin
        m_push = !stall && (mq.size() < 2 || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_inst", out_inst, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fcnt", {16'b0, fetch_cnt}, 32'h0);
    end else begin
      chk("valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_cnt", {16'b0, fetch_cnt}, m_cnt);
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_inst", out_inst, mq[0].inst);
      end
    end
    chk("misalign", {31'b0, misalign}, 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset release with consumer always ready
    tick();
    chk("r33_valid", {31'b0, out_valid}, 32'h1);
    chk("r33_pc0", out_pc, 32'h0);
    chk("r33_inst0", out_inst, 32'h0000_AA03);
    tick(); chk("r33_pc4", out_pc, 32'h4);
    tick(); chk("r33_pc8", out_pc, 32'h8);
    tick(); chk("r33_pc12", out_pc, 32'hC);
    chk("r33_fcnt", {16'b0, fetch_cnt}, 32'd4);

    // Asynchronous reset discards the buffer immediately
    rst_n = 1'b0;
    #1;
    chk("r29_valid", {31'b0, out_valid}, 32'h0);
    chk("r29_pc", out_pc, 32'h0);
    chk("r29_fcnt", {16'b0, fetch_cnt}, 32'h0);
    tick();
    out_ready = 1'b0;
    rst_n = 1'b1;

    // Back-pressure fills the buffer, then drains without gaps
    repeat (5) tick();
    chk("r34_addr", imem_addr, 32'h8);
    chk("r34_pc0", out_pc, 32'h0);
    chk("r34_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    tick(); chk("r34_pc4", out_pc, 32'h4);
    tick(); chk("r34_pc8", out_pc, 32'h8);

    // Redirect while full
    out_ready = 1'b0;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    chk("r35_valid", {31'b0, out_valid}, 32'h0);
    chk("r35_addr", imem_addr, 32'h10);
    redirect = 1'b0; out_ready = 1'b1;
    tick();
    chk("r35_pc", out_pc, 32'h10);
    chk("r35_valid2", {31'b0, out_valid}, 32'h1);

    // Redirect wins over stall; fetch resumes only after stall drops
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("r36_addr", imem_addr, 32'h40);
    chk("r36_valid", {31'b0, out_valid}, 32'h0);
    redirect = 1'b0;
    repeat (2) tick();
    chk("r36_hold_valid", {31'b0, out_valid}, 32'h0);
    chk("r36_hold_addr", imem_addr, 32'h40);
    stall = 1'b0;
    tick();
    chk("r36_pc", out_pc, 32'h40);

    // PC wraps modulo 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick(); chk("r37_pc_top", out_pc, 32'hFFFF_FFFC);
    tick(); chk("r37_pc_0", out_pc, 32'h0);
    tick(); chk("r37_pc_4", out_pc, 32'h4);

    // Misaligned redirect is fetched as given when the check is not built in
    redirect = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect = 1'b0;
    tick(); chk("r32_pc6", out_pc, 32'h6);
    tick(); chk("r32_pcA", out_pc, 32'hA);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      stall     = ($urandom_range(0, 3) == 0);
      redirect  = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      r = $urandom();
      case ($urandom_range(0, 2))
        0: redirect_pc = {r[31:2], 2'b00};
        1: redirect_pc = r;
        default: redirect_pc = 32'hFFFF_FFF0 | {28'h0, r[3:2], 2'b00};
      endcase
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    stall = 1'b0; redirect = 1'b0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
